// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   ifetch_state_t : fetch controller states (RUN, FLUSH)
//   fetch_entry_t  : one buffered fetch result {pc, instr}
//   INSTR_WIDTH    : instruction / PC width
//   PC_STEP        : byte distance between sequential instruction words
package cpu_package;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: small circular buffer holding fetched {pc, instr} entries.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   clear          synchronous flush; wins over push and pop
//   push, wr_data  write one entry (caller guarantees a free slot,
//                  or a same-cycle pop when full)
//   pop            consume the head entry (ignored when empty)
//   rd_data        head entry (meaningful only when !empty)
//   count, empty   occupancy
module fetch_fifo
  import cpu_package::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wr_data,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order fetch front end.
// Issues word reads on a valid/ready request channel, buffers in-order
// responses in fetch_fifo and presents {instruction, instr_pc} downstream on
// a valid/ready channel. A redirect clears the buffer, restarts fetch at the
// new PC and discards every response still owed by memory.
// Ports:
//   clk, reset_n                     clock / async active-low reset
//   imem_req_valid/ready/addr        read request channel
//   imem_resp_valid/data             in-order read responses
//   redirect_valid/pc                branch/jump restart
//   instr_valid/ready, instruction,
//   instr_pc                         decode-side channel
//   fetch_misaligned                 only with IFETCH_MISALIGN_CHECK_EN:
//                                    last redirect target not word aligned;
//                                    fetch is stalled while set
// Define IFETCH_MISALIGN_CHECK_EN to enable the misalignment flag; otherwise
// the low two bits of redirect_pc are silently dropped.
module instruction_fetch
  import cpu_package::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [INSTR_WIDTH-1:0] imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [INSTR_WIDTH-1:0] redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [INSTR_WIDTH-1:0] instr_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic                   fetch_misaligned
`endif
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_CMP = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0]    PC_MASK   = ~32'd3;

  ifetch_state_t    state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;   // address of next new request
  logic [31:0]      resp_pc_q, resp_pc_d;     // PC of next live response
  logic [CW-1:0]    out_q, out_d;             // accepted, not yet answered
  logic             req_valid_q, req_valid_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             stale_q, stale_d;         // pending request predates a redirect
  logic             misal_d;
  logic [31:0]      redir_pc_al;

  logic             accept, resp_hit, push, pop;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty, fifo_valid;
  fetch_entry_t     wr_entry, head;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign fifo_valid = ~fifo_empty;
  assign wr_entry   = '{pc: resp_pc_q, instr: imem_resp_data};

  always_comb begin
    accept      = req_valid_q & imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_hit    = imem_resp_valid & (out_q != '0);
    push        = resp_hit & (state_q == RUN) & ~redirect_valid;
    pop         = fifo_valid & instr_ready;
    redir_pc_al = redirect_pc & PC_MASK;

    // Dropped responses still retire their outstanding slot.
    out_d   = out_q + CW'(accept) - CW'(resp_hit);
    count_d = redirect_valid ? '0
                             : fifo_count + CW'(push) - CW'(pop);

    // A request that is still waiting for ready when a redirect arrives
    // cannot be withdrawn; remember that its response must be thrown away.
    stale_d = stale_q;
    if (accept) stale_d = 1'b0;
    if (redirect_valid & req_valid_q & ~imem_req_ready) stale_d = 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (accept & ~stale_q) fetch_pc_d = fetch_pc_q + PC_STEP;
    resp_pc_d = resp_pc_q;
    if (push) resp_pc_d = resp_pc_q + PC_STEP;
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_al;
      resp_pc_d  = redir_pc_al;
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    misal_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fetch_misaligned;
`else
    misal_d = 1'b0;
`endif

    // A stale pending request keeps us in FLUSH as well, so its response
    // can never land in RUN and be mistaken for the new stream.
    state_d = state_q;
    if (redirect_valid)
      state_d = ((out_d != '0) || stale_d) ? FLUSH : RUN;
    else if ((state_q == FLUSH) && (out_d == '0) && !stale_d)
      state_d = RUN;

    // Request valid is registered: the credit check is made on the
    // post-edge occupancy so that the registered valid behaves exactly like
    // "fifo_count + outstanding < FIFO_DEPTH" evaluated in the issue cycle.
    if (req_valid_q & ~imem_req_ready) begin
      req_valid_d = 1'b1;
      req_addr_d  = req_addr_q;
    end else begin
      req_valid_d = (state_d == RUN) & ~misal_d &
                    (({1'b0, count_d} + {1'b0, out_d}) < DEPTH_CMP);
      req_addr_d  = req_valid_d ? fetch_pc_d : req_addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      out_q       <= out_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      stale_q     <= stale_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_misaligned <= 1'b0;
    else          fetch_misaligned <= misal_d;
  end
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = fifo_valid;
  assign instruction    = fifo_valid ? head.instr : '0;
  assign instr_pc       = fifo_valid ? head.pc    : '0;

endmodule
